// File: rtl/envelope_seq_if.sv
// envelope_seq_if: note/strobe inputs and envelope state outputs of the envelope sequencer
interface envelope_seq_if;
  logic in_ready;
  logic note_on;
  logic note_off;
  logic [2:0] env_state;
  logic [3:0] env_step;
  logic env_active;
  logic note_done;
  modport master (output in_ready, note_on, note_off, input env_state, env_step, env_active, note_done);
  modport slave (input in_ready, note_on, note_off, output env_state, env_step, env_active, note_done);
endinterface

// File: rtl/envelope_seq.sv
// envelope_seq: ADSR phase/step sequencer paced by codec sample strobes
module envelope_seq #(
  parameter int STEP_LEN = 480,
  parameter int STEP_COUNT = 10
) (
  input logic clk,
  input logic rst_n,
  envelope_seq_if.slave bus
);
  typedef enum logic [2:0] {ATTACK = 3'd0, DECAY = 3'd1, SUSTAIN = 3'd2, RELEASE = 3'd3, IDLE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, active_q;
  logic counting, tick, last;
  assign counting = state_q inside {ATTACK, DECAY, RELEASE};
  assign tick = counting && bus.in_ready && cnt_q == 16'(STEP_LEN - 1);
  assign last = step_q == 4'(STEP_COUNT - 1);
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (bus.note_on) begin
      state_d = ATTACK;
      step_d = '0;
      cnt_d = '0;
    end else if (bus.note_off && state_q inside {ATTACK, DECAY, SUSTAIN}) begin
      state_d = RELEASE;
      step_d = '0;
      cnt_d = '0;
    end else if (!(state_q inside {ATTACK, DECAY, SUSTAIN, RELEASE})) begin
      state_d = IDLE;
      step_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      step_d = last ? 4'd0 : step_q + 4'd1;
      state_d = !last ? state_q : state_q == ATTACK ? DECAY : state_q == DECAY ? SUSTAIN : IDLE;
      done_d = last && state_q == RELEASE;
    end else if (counting && bus.in_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      active_q <= state_d != IDLE;
    end
  end
  assign bus.env_state = state_q;
  assign bus.env_step = step_q;
  assign bus.env_active = active_q;
  assign bus.note_done = done_q;
endmodule

// File: tb/tb_envelope_seq.sv
// tb_envelope_seq: directed scenarios plus random note traffic against a strobe-count reference model
module tb_envelope_seq;
  localparam int L = 4;
  localparam int C = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_state = 4;
  int m_n = 0;
  int m_done = 0;
  envelope_seq_if bus ();
  envelope_seq #(.STEP_LEN(L), .STEP_COUNT(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic check_all();
    check("env_state", int'(bus.env_state), m_state);
    check("env_step", int'(bus.env_step), m_n / L);
    check("env_active", int'(bus.env_active), int'(m_state != 4));
    check("note_done", int'(bus.note_done), m_done);
  endtask
  // phase position is tracked as strobes elapsed in the phase; step is derived by division
  task automatic model_step(input bit on, input bit off, input bit rdy);
    m_done = 0;
    if (on) begin
      m_state = 0;
      m_n = 0;
    end else if (off && m_state <= 2) begin
      m_state = 3;
      m_n = 0;
    end else if (rdy && m_state != 2 && m_state != 4) begin
      m_n++;
      if (m_n == L * C) begin
        m_done = int'(m_state == 3);
        m_state = m_state == 0 ? 1 : m_state == 1 ? 2 : 4;
        m_n = 0;
      end
    end
  endtask
  task automatic cycle(input bit on, input bit off, input bit rdy);
    @(negedge clk);
    bus.note_on = on;
    bus.note_off = off;
    bus.in_ready = rdy;
    @(posedge clk);
    model_step(on, off, rdy);
    #1 check_all();
  endtask
  task automatic strobes(input int k);
    for (int i = 0; i < k; i++) begin
      cycle(0, 0, 0);
      cycle(0, 0, 1);
    end
  endtask
  initial begin
    bus.note_on = 1'b0;
    bus.note_off = 1'b0;
    bus.in_ready = 1'b0;
    #12;
    check("rst_state", int'(bus.env_state), 4);
    check("rst_step", int'(bus.env_step), 0);
    check("rst_active", int'(bus.env_active), 0);
    check("rst_done", int'(bus.note_done), 0);
    rst_n = 1'b1;
    strobes(3);
    cycle(1, 0, 0);
    check("on_state", int'(bus.env_state), 0);
    check("on_active", int'(bus.env_active), 1);
    strobes(4);
    check("attack_step1", int'(bus.env_step), 1);
    strobes(36);
    check("decay_entry", int'(bus.env_state), 1);
    strobes(40);
    check("sustain_entry", int'(bus.env_state), 2);
    strobes(200);
    check("sustain_hold", int'(bus.env_step), 0);
    cycle(0, 1, 0);
    check("release_entry", int'(bus.env_state), 3);
    strobes(39);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    check("release_done", int'(bus.note_done), 1);
    check("release_idle", int'(bus.env_state), 4);
    cycle(0, 0, 0);
    check("done_one_cycle", int'(bus.note_done), 0);
    cycle(1, 0, 0);
    strobes(20);
    cycle(0, 1, 0);
    check("off_in_attack", int'(bus.env_state), 3);
    strobes(12);
    cycle(1, 0, 0);
    check("retrigger_release", int'(bus.env_state), 0);
    strobes(80);
    cycle(1, 1, 0);
    check("on_off_same", int'(bus.env_state), 0);
    cycle(0, 1, 0);
    strobes(39);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    check("off_in_idle", int'(bus.env_state), 4);
    cycle(1, 0, 0);
    strobes(39);
    cycle(0, 0, 0);
    cycle(1, 0, 1);
    check("on_beats_tick", int'(bus.env_state), 0);
    check("on_beats_tick_step", int'(bus.env_step), 0);
    cycle(0, 1, 0);
    strobes(39);
    cycle(0, 0, 0);
    cycle(1, 0, 1);
    check("on_at_release_end", int'(bus.env_state), 0);
    check("on_at_release_nodone", int'(bus.note_done), 0);
    strobes(64);
    check("pre_reset_decay6", int'(bus.env_step), 6);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(bus.env_state), 4);
    check("async_rst_step", int'(bus.env_step), 0);
    check("async_rst_active", int'(bus.env_active), 0);
    m_state = 4;
    m_n = 0;
    m_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    strobes(50);
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(59) == 0, $urandom_range(39) == 0, i[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/envelope_seq.md
ENVELOPE_SEQ -- requirements
Module: envelope_seq

Interface
REQ-001 Parameter STEP_LEN, default 480, meaning in_ready strobes per envelope step (1..65535).
REQ-002 Parameter STEP_COUNT, default 10, meaning steps per timed phase (2..16).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_ready  input  1  one-cycle sample strobe from codec path (48 kHz rate).
REQ-006 note_on  input  1  one-cycle pulse, starts or retriggers the envelope.
REQ-007 note_off  input  1  one-cycle pulse, enters release.
REQ-008 env_state  output  3  IDLE=4, ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3; bits [1:0] drive the envelope multiplier state input.
REQ-009 env_step  output  4  current step index, 0..STEP_COUNT-1, drives the multiplier step input.
REQ-010 env_active  output  1  high in every state except IDLE; downstream mutes audio when low.
REQ-011 note_done  output  1  one-cycle pulse when RELEASE completes.

Function
REQ-012 All outputs SHALL be registered; a note event on cycle N is visible on outputs at cycle N+1.
REQ-013 Internal sample counter SHALL be 16 bits, incremented only on in_ready while in ATTACK, DECAY or RELEASE.
REQ-014 Step tick SHALL occur on the in_ready cycle where sample counter == STEP_LEN-1; counter wraps to 0 on that cycle.
REQ-015 On tick with env_step < STEP_COUNT-1: env_step increments, state unchanged.
REQ-016 On tick with env_step == STEP_COUNT-1: ATTACK->DECAY, DECAY->SUSTAIN, RELEASE->IDLE; env_step and counter cleared to 0.
REQ-017 RELEASE->IDLE transition SHALL assert note_done for exactly that one cycle.
REQ-018 SUSTAIN SHALL hold indefinitely with env_step=0 and counter=0 frozen, ignoring in_ready, until note_off or note_on.
REQ-019 note_on in any state (including ATTACK, RELEASE) SHALL go to ATTACK, env_step=0, counter=0 (retrigger).
REQ-020 note_off in ATTACK, DECAY or SUSTAIN SHALL go to RELEASE, env_step=0, counter=0.
REQ-021 note_off in IDLE or RELEASE SHALL be ignored.
REQ-022 note_on and note_off in the same cycle: note_on wins.
REQ-023 Note event coinciding with a step tick: note event wins; tick discarded, note_done not asserted.
REQ-024 IDLE SHALL ignore in_ready; counter and env_step held at 0.
REQ-025 Undefined state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-026 While reset low: env_state=IDLE(4), env_step=0, env_active=0, note_done=0, counter=0, asynchronously.
REQ-027 Reset asserted mid-envelope SHALL abandon the note with no note_done pulse; first rising edge after deassertion evaluates inputs normally.

Verification (bench uses STEP_LEN=4, STEP_COUNT=10, in_ready every 2nd cycle)
REQ-028 Reset, note_on -> next cycle env_state=0, env_step=0, env_active=1; after 4 in_ready env_step=1; after 40 in_ready env_state=1, env_step=0.
REQ-029 Run through DECAY (40 more strobes) -> env_state=2, env_step stays 0 for 200 strobes; note_off -> RELEASE step 0; after 40 strobes env_state=4, env_active=0, note_done high exactly 1 cycle.
REQ-030 note_off at ATTACK step 5 -> RELEASE step 0; note_on at RELEASE step 3 -> ATTACK step 0, no note_done.
REQ-031 note_on and note_off same cycle from SUSTAIN -> ATTACK; note_off in IDLE -> no change.
REQ-032 note_on on tick cycle at ATTACK step 9 -> ATTACK step 0 (not DECAY); note_on on RELEASE final tick -> ATTACK, no note_done.
REQ-033 reset pulsed low during DECAY step 6 between clock edges -> outputs IDLE/0 immediately, no note_done afterward.
